seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring divider, one quotient bit per clock. Executes DIV (signed) and DIVU (unsigned) for the single-cycle CPU.
- Sits directly downstream of the control decoder. Consumes its start_d* pulse and returns busy_d*, which the decoder uses to stall pc_ena.
- q/r outputs feed the HI/LO selection (HI <= r, LO <= q).
- A post-completion DONE cycle ignores start, so the held DIV instruction retires without re-triggering.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE (start_d1/start_d2 from decoder).
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- dividend  input  WIDTH  rs operand; sampled with start.
- divisor  input  WIDTH  rt operand; sampled with start.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- busy  output  1  high while iterating (to busy_d1/busy_d2).
- done  output  1  one-cycle pulse; q/r valid this cycle.
- dbz  output  1  divisor was zero for the last completed operation.

Behaviour:
- Reset (async, any state): state=IDLE; q=0, r=0, busy=0, done=0, dbz=0; iteration counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch sign, the dividend and divisor magnitudes, sign_q = sign & (dividend[MSB]^divisor[MSB]), sign_r = sign & dividend[MSB].
  - Clear partial remainder, counter=WIDTH, go to RUN; busy=1 from the next cycle.
  - start=0: stay in IDLE; q/r/dbz hold.
- Magnitudes:
  - Signed mode: two's-complement absolute value, computed in WIDTH+1 bits so the most-negative value is exact.
  - Unsigned mode: operands used as-is.
- RUN, each edge:
  - Shift {rem, quo} left 1 and trial-subtract the divisor magnitude (WIDTH+1-bit).
  - Non-negative result: keep the difference, quotient LSB=1. Otherwise restore, LSB=0.
  - Decrement counter.
  - start is ignored in RUN; operand inputs may change freely.
- On the edge where counter reaches 0: state=DONE; busy=0; done=1.
- q/r are written on the same edge:
  - q = sign_q ? -quo : quo; r = sign_r ? -rem : rem.
  - Remainder takes the dividend's sign (MIPS convention).
- DONE (exactly one cycle): done=1, busy=0, start ignored; next edge returns to IDLE, done=0.
- Latency: the start edge plus WIDTH edges. busy is high for exactly WIDTH cycles; q/r are valid from the cycle busy falls until the next completion.
- Divide by zero: detected at start.
  - Completes with q={WIDTH{1}}, r=dividend (raw input, no sign fix), dbz=1.
  - Cycle count is as normal unless the optional feature is enabled.
  - dbz clears on the next completion with a nonzero divisor.
- Signed overflow: most-negative / -1 gives q=most-negative, r=0, dbz=0.
- Outputs are updated only on completion edges; a new start does not disturb q/r until that operation completes.
- Reset mid-RUN or in DONE: abort immediately to the reset values; no partial result is visible.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_DBZ_EN.
- Defined: a zero divisor at start skips RUN.
  - IDLE goes to DONE directly; busy stays 0 throughout.
  - done pulses the cycle after the start edge, with the dbz results above.
- Undefined: a zero divisor runs the full WIDTH iterations. The cycle count is identical to a normal division; the results are identical in both builds.

Test Plan:
- Unsigned basic: sign=0, 7/2 -> busy high 32 cycles; then done=1, q=0x00000003, r=0x00000001, dbz=0.
- Signed negative dividend: sign=1, 0xFFFFFFF9/0x00000002 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Same operands with sign=0 -> q=0x7FFFFFFC, r=0x00000001.
- Signed overflow: sign=1, 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0x00000000.
- Divide by zero: sign=1, 0x00000005/0 -> q=0xFFFFFFFF, r=0x00000005, dbz=1.
  - Cycle check: 32 busy cycles without the macro; busy never high and done on the next cycle with SEQ_DIVIDER_EARLY_DBZ_EN.
- Handshake: hold start=1 continuously (decoder stall model).
  - One operation runs; start is ignored during RUN and DONE.
  - A second operation begins on the first IDLE edge; q/r hold the first result until the second completes.
- Reset mid-operation: assert reset at RUN cycle 10 -> busy, done, q, r, dbz are 0 immediately (async).
  - After release, a new 100/7 unsigned operation gives q=14, r=2 after 32 busy cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro SEQ_DIVIDER_EARLY_DBZ_EN: a zero divisor skips RUN and completes on the next cycle.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; q/r/dbz hold the last result
//   RUN   | one shift/trial-subtract per edge, counter counts down
//   DONE  | single cycle with done=1; start ignored so a held start
//         | does not immediately re-trigger
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Absolute value through a WIDTH+1 extension so the most-negative input
    // yields its exact magnitude (2^(WIDTH-1)), which still fits WIDTH bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        logic [WIDTH:0] ext;
        ext = {s & x[WIDTH-1], x};
        return ext[WIDTH] ? WIDTH'(-ext) : x;
    endfunction

    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign fits    = rem_sh >= {1'b0, dvs};
    assign rem_nxt = fits ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], fits};
    assign q_fin   = dz ? '1 : (sign_q ? -quo_nxt : quo_nxt);
    assign r_fin   = dz ? dvd_raw : (sign_r ? -rem_nxt : rem_nxt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz      <= 1'b0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r  <= sign & dividend[WIDTH-1];
                        quo     <= mag(dividend, sign);
                        dvs     <= mag(divisor, sign);
                        rem     <= '0;
                        dvd_raw <= dividend;
                        dz      <= (divisor == '0);
`ifdef SEQ_DIVIDER_EARLY_DBZ_EN
                        if (divisor == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            q     <= '1;
                            r     <= dividend;
                            dbz   <= 1'b1;
                        end else begin
                            cnt   <= CW'(WIDTH);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - CW'(1);
                    // Terminal count: results are published on the same edge.
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= q_fin;
                        r     <= r_fin;
                        dbz   <= dz;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake and reset
// sequences, then random operations against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         sign;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks;
    int failures;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder
    // carries the dividend's sign; 64-bit math makes MIN/-1 harmless.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
        longint sa;
        longint sb;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == 0) begin
            eq  = '1;
            er  = a;
            edz = 1'b1;
        end else begin
            eq  = W'(sa / sb);
            er  = W'(sa % sb);
            edz = 1'b0;
        end
    endfunction

    function automatic int exp_busy(input logic [W-1:0] b);
`ifdef SEQ_DIVIDER_EARLY_DBZ_EN
        return (b == 0) ? 0 : W;
`else
        return W;
`endif
    endfunction

    // Waits (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(input string tag, output int nb);
        bit seen;
        int k;
        seen = 0;
        nb   = 0;
        k    = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) nb++;
            k++;
        end
        chk({tag, ".done_seen"}, W'(seen), W'(1));
    endtask

    task automatic do_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int nb;
        @(negedge clk);
        sign = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; sign = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
        wait_done(tag, nb);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".r"}, r, er);
        chk({tag, ".dbz"}, W'(dbz), W'(edz));
        chk({tag, ".busy_cycles"}, W'(nb), W'(exp_busy(b)));
        chk({tag, ".busy_at_done"}, W'(busy), W'(0));
        @(negedge clk);
        chk({tag, ".done_pulse"}, W'(done), W'(0));
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] eq, er, a, b;
        logic         edz, s;
        int           nb;
        int           n;

        checks = 0; failures = 0;
        start = 0; sign = 0; dividend = '0; divisor = '0;

        vecs[0] = '{1'b0, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[4] = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
        vecs[5] = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vecs[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[7] = '{1'b1, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1};
        vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[9] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.q", q, '0);
        chk("reset.r", r, '0);
        chk("reset.ctl", {29'd0, busy, done, dbz}, '0);
        reset = 1'b0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz);

        // Held start: second op launches only from IDLE, first result stays visible meanwhile.
        @(negedge clk);
        sign = 0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd3;
        wait_done("hs1", nb);
        chk("hs1.q", q, 32'd14);
        chk("hs1.r", r, 32'd2);
        @(negedge clk);
        chk("hs.idle_busy", W'(busy), W'(0));
        chk("hs.idle_done", W'(done), W'(0));
        @(negedge clk);
        chk("hs2.started", W'(busy), W'(1));
        chk("hs2.q_hold", q, 32'd14);
        wait_done("hs2", nb);
        chk("hs2.busy_cycles", W'(nb + 1), W'(W));
        chk("hs2.q", q, 32'd16);
        chk("hs2.r", r, 32'd2);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Async reset in the middle of RUN.
        sign = 1; dividend = 32'h12345678; divisor = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst.q", q, '0);
        chk("midrst.r", r, '0);
        chk("midrst.ctl", {29'd0, busy, done, dbz}, '0);
        @(negedge clk);
        reset = 1'b0;
        do_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            n = $urandom_range(0, 9);
            b = (n == 0) ? '0 : (n < 4) ? W'($urandom_range(1, 20)) : $urandom;
            if (n == 1) a = 32'h80000000;
            if (n == 2 && s) b = 32'hFFFFFFFF;
            model(s, a, b, eq, er, edz);
            do_op($sformatf("rnd%0d", i), s, a, b, eq, er, edz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
